// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write port arbiter between writeback and MDU result FIFO (optional WB_BYPASS_EN)
module wb_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     RegWriteW,
  input  logic [4:0]               RdW,
  input  logic [XLEN-1:0]          ResultW,
  input  logic                     mdu_issue,
  input  logic [4:0]               mdu_issue_rd,
  input  logic                     mdu_valid,
  input  logic [4:0]               mdu_rd,
  input  logic [XLEN-1:0]          mdu_data,
  output logic                     mdu_ready,
  input  logic [4:0]               Rs1D,
  input  logic [4:0]               Rs2D,
  output logic                     stall_d,
  output logic                     wb_hold,
  output logic                     rf_we,
  output logic [4:0]               rf_rd,
  output logic [XLEN-1:0]          rf_wd,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [7:0]    LIMIT      = 8'(STARVE_LIMIT);

  logic [4:0]      q_rd   [DEPTH];
  logic [XLEN-1:0] q_data [DEPTH];
  logic [AW-1:0]   head, tail;
  logic [CW-1:0]   count;
  logic [31:0]     busy, busy_next;
  logic [7:0]      starve, starve_next;
  logic            active;

  logic pipe_wr, empty, full, pop, accept, push, bypass;

  assign pipe_wr   = RegWriteW && (RdW != 5'd0);
  assign empty     = (count == '0);
  assign full      = (count == FULL_COUNT);
  // active keeps mdu_ready low while reset is applied and until the first edge after release
  assign mdu_ready = active && !full;
  assign accept    = mdu_valid && mdu_ready;
  assign pop       = !pipe_wr && !empty;
`ifdef WB_BYPASS_EN
  assign bypass    = empty && !pipe_wr && accept && (mdu_rd != 5'd0);
`else
  assign bypass    = 1'b0;
`endif
  assign push      = accept && (mdu_rd != 5'd0) && !bypass;
  assign fifo_count = count;

  assign stall_d = ((Rs1D != 5'd0) && busy[Rs1D]) || ((Rs2D != 5'd0) && busy[Rs2D]);

  // Write-port mux: pipeline first, then FIFO head, then (optionally) direct MDU result
  always_comb begin
    rf_we = 1'b0;
    rf_rd = 5'd0;
    rf_wd = '0;
    if (pipe_wr) begin
      rf_we = 1'b1;
      rf_rd = RdW;
      rf_wd = ResultW;
    end else if (pop) begin
      rf_we = 1'b1;
      rf_rd = q_rd[head];
      rf_wd = q_data[head];
    end else if (bypass) begin
      rf_we = 1'b1;
      rf_rd = mdu_rd;
      rf_wd = mdu_data;
    end
  end

  // Scoreboard next state: completions clear, a same-cycle issue re-sets, x0 never busy
  always_comb begin
    busy_next = busy;
    if (pop)       busy_next[q_rd[head]]  = 1'b0;
    if (bypass)    busy_next[mdu_rd]      = 1'b0;
    if (mdu_issue) busy_next[mdu_issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Starvation counter next state: count blocked drains, saturate, restart on any pop
  always_comb begin
    starve_next = starve;
    if (pop)
      starve_next = 8'd0;
    else if (!empty && pipe_wr && (starve != LIMIT))
      starve_next = starve + 8'd1;
  end

  // FIFO storage; contents are only meaningful under the count, so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[tail]   <= mdu_rd;
      q_data[tail] <= mdu_data;
    end
  end

  // Control state: pointers, occupancy, scoreboard, starvation and hold request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      busy    <= '0;
      starve  <= 8'd0;
      wb_hold <= 1'b0;
      active  <= 1'b0;
    end else begin
      active <= 1'b1;
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      busy    <= busy_next;
      starve  <= starve_next;
      wb_hold <= (starve_next == LIMIT);
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - self-checking bench for wb_port_arbiter with queue-based reference model
module tb_wb_port_arbiter;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic            clk;
  logic            rst;
  logic            RegWriteW;
  logic [4:0]      RdW;
  logic [XLEN-1:0] ResultW;
  logic            mdu_issue;
  logic [4:0]      mdu_issue_rd;
  logic            mdu_valid;
  logic [4:0]      mdu_rd;
  logic [XLEN-1:0] mdu_data;
  logic            mdu_ready;
  logic [4:0]      Rs1D, Rs2D;
  logic            stall_d, wb_hold, rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wd;
  logic [$clog2(DEPTH):0] fifo_count;

  wb_port_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .mdu_issue(mdu_issue), .mdu_issue_rd(mdu_issue_rd),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .stall_d(stall_d), .wb_hold(wb_hold),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t q[$];
  bit   busy_m[32];
  int   starve_m;
  bit   hold_m;
  bit   active_m;
  bit   m_pipe, m_pop, m_acc, m_byp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    foreach (busy_m[i]) busy_m[i] = 0;
    starve_m = 0;
    hold_m   = 0;
    active_m = 0;
  endtask

  task automatic set_idle();
    RegWriteW = 0; RdW = 0; ResultW = 0;
    mdu_issue = 0; mdu_issue_rd = 0;
    mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
    Rs1D = 0; Rs2D = 0;
  endtask

  // Check the combinational outputs for the current inputs, mid low phase
  task automatic tick_comb(input string tag);
    bit        ready, stall;
    bit        exp_we;
    logic [4:0] exp_rd;
    logic [31:0] exp_wd;
    #1;
    m_pipe = RegWriteW && (RdW != 0);
    ready  = active_m && (q.size() < DEPTH);
    m_acc  = mdu_valid && ready;
    m_pop  = !m_pipe && (q.size() > 0);
`ifdef WB_BYPASS_EN
    m_byp  = (q.size() == 0) && !m_pipe && m_acc && (mdu_rd != 0);
`else
    m_byp  = 0;
`endif
    exp_we = 0; exp_rd = 0; exp_wd = 0;
    if (m_pipe) begin
      exp_we = 1; exp_rd = RdW; exp_wd = ResultW;
    end else if (m_pop) begin
      exp_we = 1; exp_rd = q[0].rd; exp_wd = q[0].data;
    end else if (m_byp) begin
      exp_we = 1; exp_rd = mdu_rd; exp_wd = mdu_data;
    end
    stall = ((Rs1D != 0) && busy_m[Rs1D]) || ((Rs2D != 0) && busy_m[Rs2D]);
    chk({tag, ".rf_we"},     32'(rf_we),     32'(exp_we));
    chk({tag, ".rf_rd"},     32'(rf_rd),     32'(exp_rd));
    chk({tag, ".rf_wd"},     rf_wd,          exp_wd);
    chk({tag, ".stall_d"},   32'(stall_d),   32'(stall));
    chk({tag, ".mdu_ready"}, 32'(mdu_ready), 32'(ready));
  endtask

  // Clock edge: advance the model, then check registered outputs just after the edge
  task automatic tick_edge(input string tag);
    @(posedge clk);
    if (m_pop) begin
      busy_m[q[0].rd] = 0;
      q.delete(0);
      starve_m = 0;
    end else if ((q.size() > 0) && m_pipe) begin
      if (starve_m < LIMIT) starve_m++;
    end
    if (m_byp) busy_m[mdu_rd] = 0;
    if (m_acc && (mdu_rd != 0) && !m_byp) q.push_back('{rd: mdu_rd, data: mdu_data});
    if (mdu_issue && (mdu_issue_rd != 0)) busy_m[mdu_issue_rd] = 1;
    hold_m   = (starve_m == LIMIT);
    active_m = 1;
    #1;
    chk({tag, ".fifo_count"}, 32'(fifo_count), 32'(q.size()));
    chk({tag, ".wb_hold"},    32'(wb_hold),    32'(hold_m));
    chk({tag, ".ready_post"}, 32'(mdu_ready),  32'(q.size() < DEPTH));
    @(negedge clk);
  endtask

  task automatic cycle(input string tag);
    tick_comb(tag);
    tick_edge(tag);
  endtask

  initial begin
    clk = 0;
    set_idle();
    rst = 0;
    model_reset();
    #2;
    chk("por.fifo_count", 32'(fifo_count), 0);
    chk("por.mdu_ready",  32'(mdu_ready),  0);
    chk("por.wb_hold",    32'(wb_hold),    0);
    chk("por.rf_we",      32'(rf_we),      0);
    @(negedge clk);
    rst = 1;
    cycle("wakeup");

    // Queue three results behind a busy writeback, then reset mid-traffic
    for (int i = 0; i < 3; i++) begin
      set_idle();
      RegWriteW = 1; RdW = 1; ResultW = 32'h11;
      mdu_issue = 1; mdu_issue_rd = 5'(3 + i);
      mdu_valid = 1; mdu_rd = 5'(3 + i); mdu_data = 32'hA0 + 32'(i);
      cycle("fill");
    end
    chk("fill.count3", 32'(fifo_count), 3);
    set_idle();
    Rs1D = 3;
    #2;
    rst = 0;
    #1;
    chk("rst.fifo_count", 32'(fifo_count), 0);
    chk("rst.mdu_ready",  32'(mdu_ready),  0);
    chk("rst.stall_d",    32'(stall_d),    0);
    chk("rst.rf_we",      32'(rf_we),      0);
    chk("rst.wb_hold",    32'(wb_hold),    0);
    model_reset();
    @(negedge clk);
    rst = 1;
    cycle("rst_release");
    chk("rst.ready_after", 32'(mdu_ready), 1);

    // Writeback beats the FIFO head; head drains on the next idle cycle
    set_idle();
    mdu_issue = 1; mdu_issue_rd = 7;
    mdu_valid = 1; mdu_rd = 7; mdu_data = 32'h100;
    cycle("prio_push");
    set_idle();
    RegWriteW = 1; RdW = 5; ResultW = 32'h0062F433;
    tick_comb("prio_pipe");
    chk("prio.rd5", 32'(rf_rd), 5);
    chk("prio.wd5", rf_wd, 32'h0062F433);
    tick_edge("prio_pipe");
    set_idle();
    tick_comb("prio_drain");
    chk("prio.rd7", 32'(rf_rd), 7);
    chk("prio.wd7", rf_wd, 32'h100);
    tick_edge("prio_drain");

    // x0 filtering on both sources
    set_idle();
    RegWriteW = 1; RdW = 0; ResultW = 32'hDEAD;
    mdu_valid = 1; mdu_rd = 0; mdu_data = 32'hBEEF;
    tick_comb("x0");
    chk("x0.rf_we", 32'(rf_we), 0);
    tick_edge("x0");
    chk("x0.count", 32'(fifo_count), 0);

    // Fill to DEPTH under continuous writeback; fifth result refused
    for (int i = 0; i < 5; i++) begin
      set_idle();
      RegWriteW = 1; RdW = 2; ResultW = 32'(i);
      mdu_valid = 1; mdu_rd = 5'(11 + i); mdu_data = 32'hC00 + 32'(i);
      cycle("full");
    end
    chk("full.count", 32'(fifo_count), DEPTH);
    chk("full.ready", 32'(mdu_ready), 0);
    for (int i = 0; i < 4; i++) begin
      set_idle();
      cycle("full_drain");
    end

    // Scoreboard stall until the pop that writes x10
    set_idle();
    mdu_issue = 1; mdu_issue_rd = 10;
    cycle("sb_issue");
    set_idle();
    Rs1D = 10;
    RegWriteW = 1; RdW = 1;
    mdu_valid = 1; mdu_rd = 10; mdu_data = 32'h1010;
    tick_comb("sb_wait");
    chk("sb.stall_wait", 32'(stall_d), 1);
    tick_edge("sb_wait");
    set_idle();
    Rs1D = 10;
    tick_comb("sb_pop");
    chk("sb.stall_pop", 32'(stall_d), 1);
    tick_edge("sb_pop");
    tick_comb("sb_after");
    chk("sb.stall_clear", 32'(stall_d), 0);
    tick_edge("sb_after");
    // Same-cycle issue and pop for x10: bit stays set
    set_idle();
    RegWriteW = 1; RdW = 1;
    mdu_valid = 1; mdu_rd = 10; mdu_data = 32'h2020;
    cycle("sb_q2");
    set_idle();
    mdu_issue = 1; mdu_issue_rd = 10;
    cycle("sb_setwins");
    set_idle();
    Rs2D = 10;
    tick_comb("sb_still");
    chk("sb.set_wins", 32'(stall_d), 1);
    tick_edge("sb_still");
    set_idle();
    mdu_valid = 1; mdu_rd = 10; mdu_data = 32'h3030;
    cycle("sb_final");
    set_idle();
    cycle("sb_final_pop");

    // Starvation: one entry blocked for LIMIT cycles, then one idle cycle releases it
    set_idle();
    RegWriteW = 1; RdW = 4;
    mdu_valid = 1; mdu_rd = 20; mdu_data = 32'h5A5A;
    cycle("starve_push");
    for (int i = 0; i < LIMIT; i++) begin
      set_idle();
      RegWriteW = 1; RdW = 4; ResultW = 32'(i);
      cycle("starve");
      if (i == LIMIT - 2) chk("starve.hold_early", 32'(wb_hold), 0);
    end
    chk("starve.hold_set", 32'(wb_hold), 1);
    set_idle();
    tick_comb("starve_pop");
    chk("starve.pop_rd", 32'(rf_rd), 20);
    tick_edge("starve_pop");
    chk("starve.hold_clr", 32'(wb_hold), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      RegWriteW    = ($urandom_range(0, 9) < 6);
      RdW          = 5'($urandom_range(0, 31));
      ResultW      = $urandom;
      mdu_issue    = ($urandom_range(0, 9) < 3);
      mdu_issue_rd = 5'($urandom_range(0, 15));
      mdu_valid    = ($urandom_range(0, 1) == 1);
      mdu_rd       = 5'($urandom_range(0, 15));
      mdu_data     = $urandom;
      Rs1D         = 5'($urandom_range(0, 15));
      Rs2D         = 5'($urandom_range(0, 15));
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Arbitrates the single register-file write port between the in-order writeback stage and a long-latency multiply/divide unit (MDU). MDU results are buffered in a small FIFO and drained into the register file on cycles when the writeback stage is not writing. A destination-register scoreboard produces a decode stall for operands still pending in the MDU. The block sits between the writeback stage, the MDU and the register file, and feeds the hazard unit.

Parameters:
XLEN, 32, data width.
DEPTH, 4, MDU result FIFO entries; must be a power of 2 and at least 2.
STARVE_LIMIT, 8, consecutive blocked-drain cycles before wb_hold asserts; range 1..255.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-low reset.
RegWriteW  in  1  writeback-stage write enable.
RdW  in  5  writeback-stage destination register.
ResultW  in  XLEN  writeback-stage result.
mdu_issue  in  1  MDU op issued this cycle.
mdu_issue_rd  in  5  destination register of the issued MDU op.
mdu_valid  in  1  MDU result valid.
mdu_rd  in  5  MDU result destination register.
mdu_data  in  XLEN  MDU result data.
mdu_ready  out  1  FIFO can accept a result.
Rs1D  in  5  decode source register 1.
Rs2D  in  5  decode source register 2.
stall_d  out  1  decode must stall (source register pending).
wb_hold  out  1  request to hazard unit to inject a bubble.
rf_we  out  1  register-file write enable.
rf_rd  out  5  register-file write address.
rf_wd  out  XLEN  register-file write data.
fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst low, asynchronous):
  - FIFO emptied; fifo_count=0.
  - Scoreboard cleared; starvation counter=0.
  - wb_hold=0; mdu_ready=0; rf_we=0; stall_d=0.
  - Releasing reset mid-operation discards all pending results.
- pipe_wr = RegWriteW && RdW!=0. The writeback stage always wins the write port; it is never stalled by this block.
- Register-file write port:
  - If pipe_wr: rf_we=1, rf_rd=RdW, rf_wd=ResultW.
  - Else if FIFO is non-empty: pop the head entry; rf_we=1 with the head's rd and data.
  - Else rf_we=0; rf_rd and rf_wd are 0.
  - rf_* outputs are combinational.
- FIFO accept:
  - mdu_ready = !full, evaluated from the registered count only. There is no push when full, even if a pop occurs in the same cycle.
  - A result is accepted on mdu_valid && mdu_ready.
  - A result with mdu_rd==0 is accepted but not pushed.
  - A result accepted at edge N can be written to the register file no earlier than cycle N+1.
- Simultaneous push and pop: count unchanged; order preserved (strict FIFO).
- Scoreboard (32 busy bits; bit 0 is never set):
  - A bit is set at the edge where mdu_issue is high, at index mdu_issue_rd.
  - A bit is cleared when a FIFO pop writes that register.
  - Set and clear of the same index in the same cycle: set wins.
  - A pipeline writeback to a busy register does not clear its bit.
- stall_d is combinational: (Rs1D!=0 && busy[Rs1D]) || (Rs2D!=0 && busy[Rs2D]).
- Starvation counter:
  - Increments, saturating at STARVE_LIMIT, on each cycle where the FIFO is non-empty and pipe_wr=1.
  - Resets to 0 on any pop.
  - wb_hold is registered: set to 1 at the edge where the counter reaches STARVE_LIMIT; cleared at the edge following the next pop.

Optional Feature:
WB_BYPASS_EN
- Defined: when the FIFO is empty, pipe_wr=0 and mdu_valid=1 with mdu_rd!=0, the result is written straight to the register file in the same cycle and is not pushed. Zero-latency path; the scoreboard bit clears at that edge.
- Undefined: every MDU result passes through the FIFO (minimum 1-cycle latency).

Test Plan:
- Reset: rst=0 mid-traffic with 3 entries queued -> fifo_count=0, mdu_ready=0, busy clear, rf_we=0. After rst=1, mdu_ready=1.
- Priority: RegWriteW=1, RdW=5, ResultW=0x0062F433 in the same cycle as a FIFO head {rd=7, 0x00000100} -> rf writes x5; x7 is written the next idle cycle.
- x0 filtering: RegWriteW=1, RdW=0 with an empty FIFO -> rf_we=0. MDU result with rd=0 -> accepted, fifo_count stays 0.
- Full boundary: 4 results pushed while pipe_wr=1 continuously -> mdu_ready=0 after the 4th. A 5th mdu_valid is not accepted.
- Scoreboard: mdu_issue rd=10, then Rs1D=10 -> stall_d=1 until the FIFO pop writing x10, then stall_d=0 on the next cycle. An issue of rd=10 coinciding with that pop keeps the bit set.
- Starvation: FIFO holds 1 entry and pipe_wr=1 for 8 cycles -> wb_hold=1 after the 8th edge. Drop RegWriteW for one cycle -> pop occurs, wb_hold=0 at the following edge.
